serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial addition controller that sequences one external `full_adder` instance over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches the operands on a start pulse and drives the adder's a/b/cin inputs from internal shift registers. It feeds the adder's carry back through a carry flip-flop and assembles the WIDTH-bit sum. It sits between a requester that issues start/operands and a single shared combinational full adder, trading area for WIDTH cycles of latency.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range ≥ 1.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `a` in WIDTH: operand A; latched on the accepted start edge.
- `b` in WIDTH: operand B; latched on the accepted start edge.
- `cin` in 1: initial carry; latched on the accepted start edge.
- `busy` out 1: high while an addition is in progress.
- `done` out 1: one-cycle pulse; result valid.
- `sum` out WIDTH: result; holds its value until the next completion.
- `cout` out 1: final carry; holds its value until the next completion.
- `fa_a` out 1: to full_adder a.
- `fa_b` out 1: to full_adder b.
- `fa_cin` out 1: to full_adder cin.
- `fa_sum` in 1: from full_adder final_sum.
- `fa_carry` in 1: from full_adder final_carry.
- `ovf` out 1: signed overflow. Present only with SERIAL_ADD_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT.
  - IDLE with `start`=1: load a_sr←a, b_sr←b, carry_q←cin, cnt←0, sum_sr←0; go to SHIFT.
  - SHIFT, each edge: sum_sr←{fa_sum, sum_sr[WIDTH-1:1]}; carry_q←fa_carry; a_sr/b_sr shift right by 1; cnt←cnt+1.
  - SHIFT, on the edge where cnt==WIDTH-1: additionally update sum←assembled value (including the current fa_sum), cout←fa_carry, done←1; go to IDLE.
- Adder drive:
  - fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=carry_q, all driven combinationally from registers.
  - The adder is combinational; its fa_sum/fa_carry are consumed in the same cycle.
  - In IDLE, fa_a=fa_b=fa_cin=0.
- Counter width: $clog2(WIDTH+1). It never exceeds WIDTH-1 in SHIFT.
- `start` while busy is ignored; no queuing.
- Operand changes after the accepted edge have no effect.
- `busy` is a registered output: 1 exactly while state==SHIFT.
- `done` is registered: high for exactly one cycle after completion, then 0.
- `sum`/`cout` change only on completion edges.
- WIDTH=1: exactly one SHIFT cycle.

## Timing
- Reset (async assert): state IDLE, cnt 0, busy 0, done 0, sum 0, cout 0, ovf 0, fa_a/fa_b/fa_cin 0; shift registers and carry_q 0.
- Reset mid-operation aborts the addition: no done pulse, results cleared. Deassertion is synchronous to the next edge.
- Start accepted at edge E0. busy rises after E0. done rises after edge E0+WIDTH and busy falls after that same edge. Latency is WIDTH cycles from the accepting edge to done.
- Back-to-back: `start` high in the done cycle (state IDLE) is accepted. Throughput is one result per WIDTH+1 cycles.

## Configuration
- Macro `SERIAL_ADD_OVF_EN`:
  - Defined: port `ovf` exists. On completion, ovf←(carry into MSB) XOR fa_carry, i.e. carry_q XOR fa_carry on the last SHIFT cycle. It holds its value like `sum` and resets to 0.
  - Undefined: no `ovf` port and no related logic.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start at E0 → busy high E0..E8, done one cycle after E8, sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1 (macro defined).
- a=b=8'hFF, cin=1 → sum=8'hFF, cout=1. start pulsed at E3 during busy → ignored; exactly one done.
- start held high through done cycle with new a=8'h02, b=8'h03 → second op accepted in done cycle, second done 8 cycles later, sum=8'h05.
- rst asserted mid-SHIFT at cnt=3 → busy/done/sum/cout/fa_* go to 0 immediately, no done. Next start (a=1, b=1) completes with sum=8'h02.
- WIDTH=1, all 8 a/b/cin combinations → {cout,sum} equals full-adder truth table (e.g. 1,1,1 → sum=1, cout=1), done 1 cycle after each start.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one external combinational full adder over WIDTH-bit operands, LSB first
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, a, b, cin    request and operands, latched when start is seen in IDLE
//   busy                high while an addition is in progress
//   done                one-cycle pulse, sum/cout (and ovf) valid
//   sum, cout           result, held until the next completion
//   fa_a, fa_b, fa_cin  drive to the shared full adder
//   fa_sum, fa_carry    full adder outputs, consumed in the same cycle
//   ovf                 signed overflow, only when SERIAL_ADD_OVF_EN is defined
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_carry
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_q, sum_sr_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, done_q, last;
   // new sum bit enters at the MSB; written with shifts so WIDTH=1 stays legal
   assign sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
   assign last     = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && start) state_d = SHIFT;
      if (last)                     state_d = IDLE;
   end
   // carry_q still holds the final carry in IDLE, so the adder drive is gated
   always_comb begin
      busy   = state_q == SHIFT;
      fa_a   = busy & a_sr_q[0];
      fa_b   = busy & b_sr_q[0];
      fa_cin = busy & carry_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (state_q == IDLE) begin
         done_q <= 1'b0;
         if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            carry_q  <= cin;
            cnt_q    <= '0;
            sum_sr_q <= '0;
         end
      end else begin
         a_sr_q   <= a_sr_q >> 1;
         b_sr_q   <= b_sr_q >> 1;
         sum_sr_q <= sum_sr_d;
         carry_q  <= fa_carry;
         cnt_q    <= last ? '0 : cnt_q + CW'(1);
         done_q   <= last;
         if (last) begin
            sum_q  <= sum_sr_d;
            cout_q <= fa_carry;
         end
      end
   end
`ifdef SERIAL_ADD_OVF_EN
   // carry into the MSB xor carry out of the MSB
   always_ff @(posedge clk or posedge rst)
      if (rst)       ovf <= 1'b0;
      else if (last) ovf <= carry_q ^ fa_carry;
`endif
endmodule
